// File: rtl/snk68_sdram_arb.sv
// SNK68 SDRAM front end: packs ROM-download bytes into 16-bit word writes and
// shares the single read port round-robin between cpu, snd and gfx.
module snk68_sdram_arb #(
  parameter int AW = 22
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          rom_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_req,
  input  logic          snd_req,
  input  logic          gfx_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] snd_addr,
  input  logic [AW-1:0] gfx_addr,
  output logic [15:0]   cpu_dout,
  output logic [15:0]   snd_dout,
  output logic [15:0]   gfx_dout,
  output logic          cpu_valid,
  output logic          snd_valid,
  output logic          gfx_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic          mem_ack,
  input  logic [15:0]   mem_q,
  output logic          dl_overrun
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] G_CPU = 2'd0;
  localparam logic [1:0] G_SND = 2'd1;
  localparam logic [1:0] G_GFX = 2'd2;
  localparam logic [1:0] G_WR  = 2'd3;

  logic [0:0]    state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [7:0]    lo_byte_q, lo_byte_d;
  logic [AW-1:0] lo_addr_q, lo_addr_d;
  logic          lo_valid_q, lo_valid_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic          flush_q, flush_d;
  logic          dl_prev_q, dl_prev_d;
  logic          overrun_q, overrun_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;
  logic [15:0]   snd_dout_q, snd_dout_d;
  logic [15:0]   gfx_dout_q, gfx_dout_d;
  logic [2:0]    valid_q, valid_d;

  logic          byte_lo;
  logic          word_done;
  logic          dl_fall;
  logic [2:0]    req_vec;
  logic          pend_take;
  logic          rd_hit;
  logic [1:0]    rd_sel;
  logic [2:0]    cand;
  logic [AW-1:0] rd_addr;

  // Byte-address bits above the SDRAM range carry no information here.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^ioctl_addr[24:AW+1];

  assign byte_lo   = rom_download && ioctl_wr && !ioctl_addr[0];
  assign word_done = rom_download && ioctl_wr &&  ioctl_addr[0];
  assign dl_fall   = dl_prev_q && !rom_download;
  assign req_vec   = {gfx_req, snd_req, cpu_req} & {3{!rom_download}};

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    lo_byte_d   = lo_byte_q;
    lo_addr_d   = lo_addr_q;
    lo_valid_d  = lo_valid_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    flush_d     = flush_q;
    dl_prev_d   = rom_download;
    overrun_d   = overrun_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_dout_d  = cpu_dout_q;
    snd_dout_d  = snd_dout_q;
    gfx_dout_d  = gfx_dout_q;
    valid_d     = 3'b000;
    pend_take   = 1'b0;
    rd_hit      = 1'b0;
    rd_sel      = G_CPU;
    cand        = 3'd0;

    // Scan from furthest to nearest so the requester closest to rr_q wins.
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, rr_q} + k[2:0];
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req_vec[cand[1:0]]) begin
        rd_hit = 1'b1;
        rd_sel = cand[1:0];
      end
    end

    case (rd_sel)
      G_SND:   rd_addr = snd_addr;
      G_GFX:   rd_addr = gfx_addr;
      default: rd_addr = cpu_addr;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_take  = 1'b1;
          pend_d     = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = pend_addr_q;
          mem_din_d  = pend_data_q;
          gnt_d      = G_WR;
          state_d    = S_WAIT;
        end else if (flush_q) begin
          flush_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = lo_addr_q;
          mem_din_d  = {8'h00, lo_byte_q};
          gnt_d      = G_WR;
          state_d    = S_WAIT;
        end else if (rd_hit) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr;
          gnt_d      = rd_sel;
          rr_d       = (rd_sel == G_GFX) ? G_CPU : rd_sel + 2'd1;
          state_d    = S_WAIT;
        end
      end
      default: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          case (gnt_q)
            G_CPU: begin cpu_dout_d = mem_q; valid_d[0] = 1'b1; end
            G_SND: begin snd_dout_d = mem_q; valid_d[1] = 1'b1; end
            G_GFX: begin gfx_dout_d = mem_q; valid_d[2] = 1'b1; end
            default: ;
          endcase
        end
      end
    endcase

    if (byte_lo) begin
      lo_byte_d  = ioctl_dout;
      lo_addr_d  = ioctl_addr[AW:1];
      lo_valid_d = 1'b1;
    end

    // A word landing on top of an unissued one replaces it.
    if (word_done) begin
      if (pend_q && !pend_take) overrun_d = 1'b1;
      pend_d      = 1'b1;
      pend_addr_d = ioctl_addr[AW:1];
      pend_data_d = {ioctl_dout, lo_byte_q};
      lo_valid_d  = 1'b0;
    end

    if (dl_fall && lo_valid_q) begin
      flush_d    = 1'b1;
      lo_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= G_CPU;
      gnt_q       <= G_CPU;
      lo_byte_q   <= '0;
      lo_addr_q   <= '0;
      lo_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      flush_q     <= 1'b0;
      dl_prev_q   <= 1'b0;
      overrun_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_dout_q  <= '0;
      snd_dout_q  <= '0;
      gfx_dout_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      lo_byte_q   <= lo_byte_d;
      lo_addr_q   <= lo_addr_d;
      lo_valid_q  <= lo_valid_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      flush_q     <= flush_d;
      dl_prev_q   <= dl_prev_d;
      overrun_q   <= overrun_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_dout_q  <= cpu_dout_d;
      snd_dout_q  <= snd_dout_d;
      gfx_dout_q  <= gfx_dout_d;
      valid_q     <= valid_d;
    end
  end

  assign cpu_dout   = cpu_dout_q;
  assign snd_dout   = snd_dout_q;
  assign gfx_dout   = gfx_dout_q;
  assign cpu_valid  = valid_q[0];
  assign snd_valid  = valid_q[1];
  assign gfx_valid  = valid_q[2];
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign dl_overrun = overrun_q;

endmodule

// File: tb/tb_snk68_sdram_arb.sv
// Directed bench for snk68_sdram_arb with a simple SDRAM responder and
// hand-computed expected transactions.
module tb_snk68_sdram_arb;

  localparam int AW = 22;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } txn_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          rom_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          cpu_req, snd_req, gfx_req;
  logic [AW-1:0] cpu_addr, snd_addr, gfx_addr;
  logic [15:0]   cpu_dout, snd_dout, gfx_dout;
  logic          cpu_valid, snd_valid, gfx_valid;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_ack;
  logic [15:0]   mem_q;
  logic          dl_overrun;

  int   checks = 0;
  int   errors = 0;
  int   ack_lat = 4;
  txn_t log_q[$];
  int   n_cpu = 0, n_snd = 0, n_gfx = 0, n_dbl = 0;
  logic [2:0] vprev = 3'b000;

  always #5 clk_sys = ~clk_sys;

  snk68_sdram_arb #(.AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .rom_download(rom_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_req(cpu_req), .snd_req(snd_req), .gfx_req(gfx_req),
    .cpu_addr(cpu_addr), .snd_addr(snd_addr), .gfx_addr(gfx_addr),
    .cpu_dout(cpu_dout), .snd_dout(snd_dout), .gfx_dout(gfx_dout),
    .cpu_valid(cpu_valid), .snd_valid(snd_valid), .gfx_valid(gfx_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_q(mem_q), .dl_overrun(dl_overrun)
  );

  // SDRAM responder: logs each transaction, acks ack_lat cycles later with mem_q = address
  initial begin
    mem_ack = 1'b0;
    mem_q   = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (mem_req === 1'b1) begin
        log_q.push_back('{we: mem_we, addr: mem_addr, din: mem_din});
        repeat (ack_lat - 1) @(negedge clk_sys);
        mem_q   = mem_addr[15:0];
        mem_ack = 1'b1;
        @(negedge clk_sys);
        mem_ack = 1'b0;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (cpu_valid === 1'b1) n_cpu++;
    if (snd_valid === 1'b1) n_snd++;
    if (gfx_valid === 1'b1) n_gfx++;
    if ((vprev & {gfx_valid, snd_valid, cpu_valid}) != 3'b000) n_dbl++;
    vprev = {gfx_valid, snd_valid, cpu_valid};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
    tick(gap);
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk_sys);
    chk(tag, 64'(log_q.size()), 64'(n));
  endtask

  task automatic wait_valid(input int which, input int budget, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_sys);
      case (which)
        0:       got = cpu_valid;
        1:       got = snd_valid;
        default: got = gfx_valid;
      endcase
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   c0, s0, g0, lsz;
    reset = 1'b1; rom_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cpu_req = 1'b0; snd_req = 1'b0; gfx_req = 1'b0;
    cpu_addr = '0; snd_addr = '0; gfx_addr = '0;
    tick(3);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_din, cpu_valid, snd_valid, gfx_valid, dl_overrun}, 64'd0);
    chk("rst_dout", {cpu_dout, snd_dout, gfx_dout}, 64'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    tick(2);

    // Two full words, bus idle between them
    ack_lat = 4;
    rom_download = 1'b1;
    tick(1);
    send_byte(25'h0, 8'h11, 8);
    send_byte(25'h1, 8'h22, 8);
    send_byte(25'h2, 8'h33, 8);
    send_byte(25'h3, 8'h44, 8);
    rom_download = 1'b0;
    tick(10);
    chk("t1_count", 64'(log_q.size()), 64'd2);
    chk("t1_w0", 64'(log_q[0]), 64'({1'b1, 22'h0, 16'h2211}));
    chk("t1_w1", 64'(log_q[1]), 64'({1'b1, 22'h1, 16'h4433}));
    chk("t1_ovr", 64'(dl_overrun), 64'd0);

    // Odd trailing byte flushed when the download ends
    log_q.delete();
    rom_download = 1'b1;
    tick(1);
    send_byte(25'h10, 8'hAA, 8);
    send_byte(25'h11, 8'hBB, 8);
    send_byte(25'h12, 8'hCC, 8);
    rom_download = 1'b0;
    tick(20);
    chk("t2_count", 64'(log_q.size()), 64'd2);
    chk("t2_w0", 64'(log_q[0]), 64'({1'b1, 22'h8, 16'hBBAA}));
    chk("t2_flush", 64'(log_q[1]), 64'({1'b1, 22'h9, 16'h00CC}));

    // Back-to-back words against a slow ack: middle word is overwritten
    log_q.delete();
    ack_lat = 10;
    rom_download = 1'b1;
    tick(1);
    send_byte(25'h20, 8'h01, 0);
    send_byte(25'h21, 8'h02, 0);
    send_byte(25'h22, 8'h03, 0);
    send_byte(25'h23, 8'h04, 0);
    send_byte(25'h24, 8'h05, 0);
    send_byte(25'h25, 8'h06, 0);
    tick(1);
    chk("t3_ovr_set", 64'(dl_overrun), 64'd1);
    rom_download = 1'b0;
    tick(40);
    chk("t3_count", 64'(log_q.size()), 64'd2);
    chk("t3_w0", 64'(log_q[0]), 64'({1'b1, 22'h10, 16'h0201}));
    chk("t3_wlast", 64'(log_q[1]), 64'({1'b1, 22'h12, 16'h0605}));
    chk("t3_ovr_hold", 64'(dl_overrun), 64'd1);

    // Round-robin with all three requesting
    log_q.delete();
    ack_lat = 3;
    c0 = n_cpu; s0 = n_snd; g0 = n_gfx;
    cpu_addr = 22'h100; snd_addr = 22'h200; gfx_addr = 22'h300;
    cpu_req = 1'b1; snd_req = 1'b1; gfx_req = 1'b1;
    wait_log(4, 200, "t4_wait");
    cpu_req = 1'b0; snd_req = 1'b0; gfx_req = 1'b0;
    tick(12);
    chk("t4_g0", {log_q[0].we, log_q[0].addr}, {1'b0, 22'h100});
    chk("t4_g1", {log_q[1].we, log_q[1].addr}, {1'b0, 22'h200});
    chk("t4_g2", {log_q[2].we, log_q[2].addr}, {1'b0, 22'h300});
    chk("t4_g3", {log_q[3].we, log_q[3].addr}, {1'b0, 22'h100});
    chk("t4_count", 64'(log_q.size()), 64'd4);
    chk("t4_nvalid", {32'(n_cpu - c0), 16'(n_snd - s0), 16'(n_gfx - g0)}, {32'd2, 16'd1, 16'd1});
    chk("t4_douts", {cpu_dout, snd_dout, gfx_dout}, {16'h0100, 16'h0200, 16'h0300});
    chk("t4_pulse", 64'(n_dbl), 64'd0);

    // Reads held off while downloading
    log_q.delete();
    c0 = n_cpu;
    rom_download = 1'b1;
    cpu_addr = 22'h55;
    cpu_req = 1'b1;
    tick(10);
    chk("t5_no_txn", 64'(log_q.size()), 64'd0);
    chk("t5_no_valid", 64'(n_cpu - c0), 64'd0);
    rom_download = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk_sys);
      if (mem_req === 1'b1) seen = 1'b1;
    end
    chk("t5_issue", 64'(seen), 64'd1);
    wait_valid(0, 30, "t5_valid");
    cpu_req = 1'b0;
    tick(10);
    chk("t5_dout", 64'(cpu_dout), 64'h0055);
    chk("t5_txn", {log_q[0].we, log_q[0].addr}, {1'b0, 22'h55});
    chk("t5_count", 64'(log_q.size()), 64'd1);

    // Asynchronous reset during WAIT, then a stray ack
    ack_lat = 6;
    cpu_addr = 22'h77;
    cpu_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_sys);
      if (mem_req === 1'b1) seen = 1'b1;
    end
    chk("t6_started", 64'(seen), 64'd1);
    cpu_req = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_mem", {mem_req, mem_we, mem_addr, mem_din, cpu_valid, snd_valid, gfx_valid, dl_overrun}, 64'd0);
    chk("t6_rst_dout", {cpu_dout, snd_dout, gfx_dout}, 64'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    c0 = n_cpu; s0 = n_snd; g0 = n_gfx; lsz = log_q.size();
    tick(15);
    chk("t6_stray", 64'((n_cpu - c0) + (n_snd - s0) + (n_gfx - g0)), 64'd0);
    chk("t6_no_txn", 64'(log_q.size()), 64'(lsz));
    cpu_addr = 22'h99;
    cpu_req = 1'b1;
    wait_valid(0, 30, "t6_valid");
    cpu_req = 1'b0;
    tick(2);
    chk("t6_dout", 64'(cpu_dout), 64'h0099);
    chk("t6_pulse", 64'(n_dbl), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
